// File: rtl/sap_ctrl_pkg.sv
// sap_ctrl_pkg: control-bit map, opcodes, fetch words and execute microcode table for the SAP sequencer
package sap_ctrl_pkg;
    localparam int B_HLT = 15;
    localparam int B_J   = 1;
    localparam int B_NXT = 0;
    localparam logic [15:0] M_HLT = 16'h8000;
    localparam logic [15:0] M_MI  = 16'h4000;
    localparam logic [15:0] M_RI  = 16'h2000;
    localparam logic [15:0] M_RO  = 16'h1000;
    localparam logic [15:0] M_IO  = 16'h0800;
    localparam logic [15:0] M_II  = 16'h0400;
    localparam logic [15:0] M_AI  = 16'h0200;
    localparam logic [15:0] M_AO  = 16'h0100;
    localparam logic [15:0] M_EO  = 16'h0080;
    localparam logic [15:0] M_SU  = 16'h0040;
    localparam logic [15:0] M_BI  = 16'h0020;
    localparam logic [15:0] M_OI  = 16'h0010;
    localparam logic [15:0] M_CE  = 16'h0008;
    localparam logic [15:0] M_CO  = 16'h0004;
    localparam logic [15:0] M_J   = 16'h0002;
    localparam logic [15:0] M_NXT = 16'h0001;
    localparam logic [7:0] OP_NOP = 8'd0;
    localparam logic [7:0] OP_LDA = 8'd1;
    localparam logic [7:0] OP_ADD = 8'd2;
    localparam logic [7:0] OP_SUB = 8'd3;
    localparam logic [7:0] OP_STA = 8'd4;
    localparam logic [7:0] OP_LDI = 8'd5;
    localparam logic [7:0] OP_JMP = 8'd6;
    localparam logic [7:0] OP_JC  = 8'd7;
    localparam logic [7:0] OP_JZ  = 8'd8;
    localparam logic [7:0] OP_OUT = 8'd14;
    localparam logic [7:0] OP_HLT = 8'd15;
    localparam logic [15:0] T0_CW = M_MI | M_CO;
    localparam logic [15:0] T1_CW = M_RO | M_II | M_CE;

    function automatic logic is_legal(input logic [7:0] op);
        return op <= OP_JZ || op == OP_OUT || op == OP_HLT;
    endfunction

    // execute-phase words; anything not listed (including undefined opcodes) behaves as NOP
    function automatic logic [15:0] ucode_lookup(input logic [7:0] op, input logic [3:0] st);
        logic [15:0] cw;
        case (op)
            OP_LDA: cw = st == 4'd2 ? M_IO | M_MI : st == 4'd3 ? M_RO | M_AI | M_NXT : '0;
            OP_ADD: cw = st == 4'd2 ? M_IO | M_MI : st == 4'd3 ? M_RO | M_BI : st == 4'd4 ? M_EO | M_AI | M_NXT : '0;
            OP_SUB: cw = st == 4'd2 ? M_IO | M_MI : st == 4'd3 ? M_RO | M_BI : st == 4'd4 ? M_EO | M_SU | M_AI | M_NXT : '0;
            OP_STA: cw = st == 4'd2 ? M_IO | M_MI : st == 4'd3 ? M_AO | M_RI | M_NXT : '0;
            OP_LDI: cw = st == 4'd2 ? M_IO | M_AI | M_NXT : '0;
            OP_JMP, OP_JC, OP_JZ: cw = st == 4'd2 ? M_IO | M_J | M_NXT : '0;
            OP_OUT: cw = st == 4'd2 ? M_AO | M_OI | M_NXT : '0;
            OP_HLT: cw = st == 4'd2 ? M_HLT : '0;
            default: cw = st == 4'd2 ? M_NXT : '0;
        endcase
        return cw;
    endfunction
endpackage

// File: rtl/sap_ucode_rom.sv
// sap_ucode_rom: combinational fetch/execute table with flag-qualified jump; SAP_ILLEGAL_TRAP_EN enables illegal-opcode reporting
module sap_ucode_rom
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic [1:0]          flags,
    output logic [15:0]         cw,
    output logic                illegal
);
    logic [7:0]  op;
    logic [3:0]  st;
    logic [15:0] raw;
    logic        j_ok;

    // fetch words are opcode-independent; JC/JZ keep IO and NXT but drop J when the flag is clear
    always_comb begin
        op = 8'(opcode);
        st = 4'(step);
        raw = st == 4'd0 ? T0_CW : st == 4'd1 ? T1_CW : ucode_lookup(op, st);
        j_ok = op == OP_JC ? flags[0] : op == OP_JZ ? flags[1] : 1'b1;
        cw = j_ok ? raw : raw & ~M_J;
`ifdef SAP_ILLEGAL_TRAP_EN
        illegal = !is_legal(op);
`else
        illegal = 1'b0;
`endif
    end
endmodule

// File: rtl/sap_microcode_sequencer.sv
// sap_microcode_sequencer: falling-edge microstep counter, halt and run gating around the microcode ROM; SAP_ILLEGAL_TRAP_EN adds illegal_op
module sap_microcode_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int NUM_STEPS = 8,
    parameter int CW_W      = 16,
    localparam int STEP_W   = $clog2(NUM_STEPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          flags,
    input  logic                step_en,
    output logic [CW_W-1:0]     ctrl_word,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
`ifdef SAP_ILLEGAL_TRAP_EN
    output logic                illegal_op,
`endif
    output logic                halted
);
    localparam logic [STEP_W-1:0] LAST  = STEP_W'(NUM_STEPS - 1);
    localparam logic [STEP_W-1:0] EXEC0 = STEP_W'(2);

    logic [15:0] rom_cw;
    logic [15:0] cw;
    logic        rom_illegal;
    logic        active;
    logic        trap;
    logic        wrap;

    sap_ucode_rom #(.OPCODE_W(OPCODE_W), .STEP_W(STEP_W)) u_rom (
        .opcode  (opcode),
        .step    (step),
        .flags   (flags),
        .cw      (rom_cw),
        .illegal (rom_illegal)
    );

    // gate the decoded word by reset, halt and the run switch; the last step always ends the instruction
    always_comb begin
        active = reset & step_en & !halted;
        trap = active & rom_illegal & (step == EXEC0);
        cw = trap ? '0 : rom_cw;
        wrap = cw[B_NXT] | (step == LAST);
        ctrl_word = CW_W'(!reset ? 16'h0000 : halted ? M_HLT : active ? cw : 16'h0000);
        instr_done = active & !trap & wrap;
    end

    // step and halt advance on the falling edge so the word is settled at the datapath's rising edge
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            step <= '0;
            halted <= 1'b0;
        end else if (active) begin
            step <= wrap ? '0 : step + STEP_W'(1);
            halted <= cw[B_HLT] | trap;
        end
    end

`ifdef SAP_ILLEGAL_TRAP_EN
    // illegal-opcode indication stays set until reset
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) illegal_op <= 1'b0;
        else if (trap) illegal_op <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sap_microcode_sequencer.sv
// tb_sap_microcode_sequencer: randomized scoreboard bench for NUM_STEPS=8 and NUM_STEPS=3 sequencers sharing one stimulus stream
module tb_sap_microcode_sequencer;
`ifdef SAP_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [15:0] cw;
        int          st;
        logic        done;
        logic        h;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  opcode = '0;
    logic [1:0]  flags = '0;
    logic        step_en = 1'b1;
    logic [15:0] cw0, cw1;
    logic [2:0]  st0;
    logic [1:0]  st1;
    logic        done0, done1, h0, h1, il0, il1;

    logic [15:0] exe [16][3];
    int          m_st [2];
    logic        m_h [2];
    logic        m_il [2];
    int          ns [2] = '{8, 3};
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    sap_microcode_sequencer #(.NUM_STEPS(8)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags), .step_en(step_en),
        .ctrl_word(cw0), .step(st0), .instr_done(done0),
`ifdef SAP_ILLEGAL_TRAP_EN
        .illegal_op(il0),
`endif
        .halted(h0)
    );

    sap_microcode_sequencer #(.NUM_STEPS(3)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags), .step_en(step_en),
        .ctrl_word(cw1), .step(st1), .instr_done(done1),
`ifdef SAP_ILLEGAL_TRAP_EN
        .illegal_op(il1),
`endif
        .halted(h1)
    );

`ifndef SAP_ILLEGAL_TRAP_EN
    assign il0 = 1'b0;
    assign il1 = 1'b0;
`endif

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] t=%0t got=%0h expected=%0h", nm, i, $time, act, exp);
        end
    endtask

    // one clock of stimulus: drive after the falling edge, record what each sequencer must show until the next one
    task automatic cycle(input logic [3:0] op, input logic [1:0] fl, input logic en, input logic rst);
        @(negedge clk);
        #1;
        opcode = op;
        flags = fl;
        step_en = en;
        reset = rst;
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            logic [15:0] w;
            logic tr, last, run;
            if (!rst) begin
                m_st[i] = 0;
                m_h[i] = 1'b0;
                m_il[i] = 1'b0;
            end
            last = m_st[i] == ns[i] - 1;
            w = m_st[i] == 0 ? 16'h4004 : m_st[i] == 1 ? 16'h1408 : m_st[i] <= 4 ? exe[op][m_st[i] - 2] : 16'h0000;
            if ((op == 4'd7 && !fl[0]) || (op == 4'd8 && !fl[1])) w[1] = 1'b0;
            tr = TRAP && op > 4'd8 && op < 4'd14 && m_st[i] == 2;
            if (tr) w = 16'h0000;
            run = rst && en && !m_h[i];
            x.cw = !rst ? 16'h0000 : m_h[i] ? 16'h8000 : run ? w : 16'h0000;
            x.done = run && !tr && (w[0] || last);
            x.st = m_st[i];
            x.h = m_h[i];
            x.il = m_il[i];
            if (i == 0) q0.push_back(x);
            else q1.push_back(x);
            if (run) begin
                if (w[15] || tr) m_h[i] = 1'b1;
                if (tr) m_il[i] = 1'b1;
                m_st[i] = (w[0] || last) ? 0 : m_st[i] + 1;
            end
        end
    endtask

    // monitor: compare the outputs mid-cycle against the oldest recorded expectation
    always @(posedge clk) begin
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("ctrl_word", 0, 32'(cw0), 32'(e.cw));
            chk("step", 0, 32'(st0), 32'(e.st));
            chk("instr_done", 0, 32'(done0), 32'(e.done));
            chk("halted", 0, 32'(h0), 32'(e.h));
            if (TRAP) chk("illegal_op", 0, 32'(il0), 32'(e.il));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("ctrl_word", 1, 32'(cw1), 32'(e.cw));
            chk("step", 1, 32'(st1), 32'(e.st));
            chk("instr_done", 1, 32'(done1), 32'(e.done));
            chk("halted", 1, 32'(h1), 32'(e.h));
            if (TRAP) chk("illegal_op", 1, 32'(il1), 32'(e.il));
        end
    end

    initial begin
        logic [3:0] op;
        for (int o = 0; o < 16; o++) exe[o] = '{16'h0001, 16'h0000, 16'h0000};
        exe[1]  = '{16'h4800, 16'h1201, 16'h0000};
        exe[2]  = '{16'h4800, 16'h1020, 16'h0281};
        exe[3]  = '{16'h4800, 16'h1020, 16'h02C1};
        exe[4]  = '{16'h4800, 16'h2101, 16'h0000};
        exe[5]  = '{16'h0A01, 16'h0000, 16'h0000};
        exe[6]  = '{16'h0803, 16'h0000, 16'h0000};
        exe[7]  = '{16'h0803, 16'h0000, 16'h0000};
        exe[8]  = '{16'h0803, 16'h0000, 16'h0000};
        exe[14] = '{16'h0111, 16'h0000, 16'h0000};
        exe[15] = '{16'h8000, 16'h0000, 16'h0000};
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_h[i] = 1'b0;
            m_il[i] = 1'b0;
        end
        repeat (2) cycle(4'd2, 2'b00, 1'b1, 1'b0);
        repeat (6) cycle(4'd2, 2'b00, 1'b1, 1'b1);
        repeat (2) cycle(4'd7, 2'b01, 1'b1, 1'b1);
        repeat (3) cycle(4'd7, 2'b00, 1'b1, 1'b1);
        repeat (3) cycle(4'd8, 2'b10, 1'b1, 1'b1);
        repeat (3) cycle(4'd8, 2'b01, 1'b1, 1'b1);
        repeat (3) cycle(4'd1, 2'b00, 1'b1, 1'b1);
        repeat (3) cycle(4'd1, 2'b00, 1'b0, 1'b1);
        cycle(4'd1, 2'b00, 1'b1, 1'b1);
        repeat (3) cycle(4'd2, 2'b00, 1'b1, 1'b1);
        cycle(4'd2, 2'b00, 1'b1, 1'b0);
        repeat (2) cycle(4'd2, 2'b00, 1'b1, 1'b1);
        repeat (4) cycle(4'd10, 2'b00, 1'b1, 1'b1);
        cycle(4'd0, 2'b00, 1'b1, 1'b0);
        repeat (3) cycle(4'd15, 2'b00, 1'b1, 1'b1);
        repeat (10) cycle(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
        cycle(4'd0, 2'b00, 1'b1, 1'b0);
        op = 4'd0;
        repeat (800) begin
            if (m_st[0] == 0) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd15 && $urandom_range(0, 3) != 0) op = 4'd2;
            end
            cycle(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 59) != 0));
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d expected=0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
